mod_exp_lr: RTL and testbench

Parametrised left-to-right modular exponentiation engine. It computes y = a^exp mod m for an odd modulus of runtime-selectable size, with a runtime exponent length and an optional constant-time multiply mode. It is the next-generation exponentiation core of the public-key datapath and contains its own bit-serial radix-2 Montgomery multiplier. A start/busy/done handshake, an abort, and an error flag make it directly usable from a register-mapped controller.

---
 rtl/mod_exp_lr.sv | 211 +++++++++++++++++++++
 tb/tb_mod_exp_lr.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_exp_lr.sv
// Left-to-right modular exponentiation y = a^exp mod m, driven by a
// bit-serial radix-2 Montgomery multiplier with R = 2^m_size.
module mod_exp_lr #(
  parameter int NBITS      = 256,
  parameter int EBITS      = 256,
  parameter int SZW        = 12,
  parameter int CONST_TIME = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_p,
  input  logic             abort_p,
  input  logic [NBITS-1:0] a,
  input  logic [EBITS-1:0] exp,
  input  logic [SZW-1:0]   e_size,
  input  logic [NBITS-1:0] m,
  input  logic [SZW-1:0]   m_size,
  input  logic [NBITS-1:0] r_red,
  output logic [NBITS-1:0] y,
  output logic             busy,
  output logic             done_p,
  output logic             err
);

  // state     | meaning
  // S_IDLE    | waiting for start_p
  // S_CONV_A  | A = MM(a, R^2), base into Montgomery domain
  // S_CONV_R  | X = MM(1, R^2) = R mod m
  // S_SQR     | X = MM(X, X) for exponent bit bidx
  // S_MUL     | MM(X, A); committed to X only when exp[bidx] = 1
  // S_FROM_MONT | y = MM(X, 1), leave Montgomery domain
  // Each operating state runs one multiply: P_LOAD, m_size x P_ITER, P_FIN.

  typedef enum logic [2:0] {
    S_IDLE, S_CONV_A, S_CONV_R, S_SQR, S_MUL, S_FROM_MONT
  } state_t;

  typedef enum logic [1:0] {P_LOAD, P_ITER, P_FIN} phase_t;

  localparam int               EIW    = (EBITS > 1) ? $clog2(EBITS) : 1;
  localparam logic [SZW-1:0]   NB_MAX = SZW'(NBITS);
  localparam logic [SZW-1:0]   EB_MAX = SZW'(EBITS);
  localparam logic [NBITS-1:0] ONE    = NBITS'(1);
  localparam logic             CT     = (CONST_TIME != 0);

  state_t state, state_nx;
  phase_t phase, phase_nx;

  logic [NBITS-1:0] a_r, m_r, r_red_r;
  logic [EBITS-1:0] exp_r;
  logic [SZW-1:0]   e_size_r, m_size_r;
  logic [NBITS-1:0] a_mont, x_acc, x_sh;
  logic [NBITS+1:0] acc;
  logic [SZW-1:0]   cnt, bidx;

  logic             bad_ops, accept, reject;
  logic             exp_bit, bidx_last;
  logic [NBITS-1:0] x_sel, z_sel, mm_res;
  logic [NBITS+1:0] t_add, t_red;

  assign busy      = (state != S_IDLE);
  assign bad_ops   = !m[0] || (m_size == '0) || (m_size > NB_MAX) || (e_size > EB_MAX);
  assign exp_bit   = exp_r[bidx[EIW-1:0]];
  assign bidx_last = (bidx == '0);

  always_comb begin
    x_sel = x_acc;
    z_sel = x_acc;
    case (state)
      S_CONV_A: begin
        x_sel = a_r;
        z_sel = r_red_r;
      end
      S_CONV_R: begin
        x_sel = ONE;
        z_sel = r_red_r;
      end
      S_MUL:       z_sel = a_mont;
      S_FROM_MONT: z_sel = ONE;
      default: ;
    endcase
  end

  // acc stays below 2m, so t_red < 4m fits in NBITS+2 bits
  assign t_add  = acc + (x_sh[0] ? {2'b00, z_sel} : '0);
  assign t_red  = t_add + (t_add[0] ? {2'b00, m_r} : '0);
  assign mm_res = (acc >= {2'b00, m_r}) ? (acc[NBITS-1:0] - m_r) : acc[NBITS-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      phase <= P_LOAD;
    end else begin
      state <= state_nx;
      phase <= phase_nx;
    end
  end

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    accept   = 1'b0;
    reject   = 1'b0;
    if (state == S_IDLE) begin
      if (start_p) begin
        if (bad_ops) begin
          reject = 1'b1;
        end else begin
          accept   = 1'b1;
          state_nx = S_CONV_A;
          phase_nx = P_LOAD;
        end
      end
    end else if (abort_p) begin
      state_nx = S_IDLE;
      phase_nx = P_LOAD;
    end else begin
      case (phase)
        P_LOAD: phase_nx = P_ITER;
        P_ITER: if (cnt == SZW'(1)) phase_nx = P_FIN;
        default: begin
          phase_nx = P_LOAD;
          case (state)
            S_CONV_A: state_nx = S_CONV_R;
            S_CONV_R: state_nx = (e_size_r == '0) ? S_FROM_MONT : S_SQR;
            S_SQR: begin
              if (exp_bit || CT)  state_nx = S_MUL;
              else if (bidx_last) state_nx = S_FROM_MONT;
              else                state_nx = S_SQR;
            end
            S_MUL:   state_nx = bidx_last ? S_FROM_MONT : S_SQR;
            default: state_nx = S_IDLE;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y        <= '0;
      done_p   <= 1'b0;
      err      <= 1'b0;
      a_r      <= '0;
      m_r      <= '0;
      r_red_r  <= '0;
      exp_r    <= '0;
      e_size_r <= '0;
      m_size_r <= '0;
      a_mont   <= '0;
      x_acc    <= '0;
      x_sh     <= '0;
      acc      <= '0;
      cnt      <= '0;
      bidx     <= '0;
    end else begin
      done_p <= 1'b0;
      if (reject) begin
        done_p <= 1'b1;
        err    <= 1'b1;
        y      <= '0;
      end
      if (accept) begin
        a_r      <= a;
        m_r      <= m;
        r_red_r  <= r_red;
        exp_r    <= exp;
        e_size_r <= e_size;
        m_size_r <= m_size;
        err      <= 1'b0;
      end
      if (busy && !abort_p) begin
        case (phase)
          P_LOAD: begin
            x_sh <= x_sel;
            acc  <= '0;
            cnt  <= m_size_r;
          end
          P_ITER: begin
            x_sh <= x_sh >> 1;
            acc  <= t_red >> 1;
            cnt  <= cnt - SZW'(1);
          end
          default: begin
            case (state)
              S_CONV_A: a_mont <= mm_res;
              S_CONV_R: begin
                x_acc <= mm_res;
                bidx  <= e_size_r - SZW'(1);
              end
              S_SQR: begin
                x_acc <= mm_res;
                if (!exp_bit && !CT && !bidx_last) bidx <= bidx - SZW'(1);
              end
              S_MUL: begin
                // dummy product for a 0 bit is simply not committed
                if (exp_bit) x_acc <= mm_res;
                if (!bidx_last) bidx <= bidx - SZW'(1);
              end
              default: begin
                y      <= mm_res;
                done_p <= 1'b1;
              end
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mod_exp_lr.sv
// Bench for mod_exp_lr: directed vector table on 8-bit plain and constant-time
// instances, randomized runs on 8- and 16-bit instances against a pow model.
module tb_mod_exp_lr;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start8, abort8;
  logic [7:0]  a8, exp8, m8, rr8;
  logic [11:0] esz8, msz8;
  logic [7:0]  y0, y1;
  logic        busy0, busy1, done0, done1, err0, err1;

  logic        start16, abort16;
  logic [15:0] a16, exp16, m16, rr16;
  logic [11:0] esz16, msz16;
  logic [15:0] y16;
  logic        busy16, done16, err16;

  mod_exp_lr #(.NBITS(8), .EBITS(8), .SZW(12), .CONST_TIME(0)) u_plain (
    .clk(clk), .rst_n(rst_n), .start_p(start8), .abort_p(abort8), .a(a8), .exp(exp8),
    .e_size(esz8), .m(m8), .m_size(msz8), .r_red(rr8), .y(y0), .busy(busy0),
    .done_p(done0), .err(err0));

  mod_exp_lr #(.NBITS(8), .EBITS(8), .SZW(12), .CONST_TIME(1)) u_ct (
    .clk(clk), .rst_n(rst_n), .start_p(start8), .abort_p(abort8), .a(a8), .exp(exp8),
    .e_size(esz8), .m(m8), .m_size(msz8), .r_red(rr8), .y(y1), .busy(busy1),
    .done_p(done1), .err(err1));

  mod_exp_lr #(.NBITS(16), .EBITS(16), .SZW(12), .CONST_TIME(0)) u_wide (
    .clk(clk), .rst_n(rst_n), .start_p(start16), .abort_p(abort16), .a(a16), .exp(exp16),
    .e_size(esz16), .m(m16), .m_size(msz16), .r_red(rr16), .y(y16), .busy(busy16),
    .done_p(done16), .err(err16));

  typedef struct {
    longint a, e, esz, m, msz, rr, y, err, cyc, cyc_ct;
  } vec8_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     dc0, dc1, nd0, nd1;
  longint ys0, ys1, es0, es1;
  bit     blog0[0:255];
  bit     blog1[0:255];
  vec8_t  tbl[10];

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // right-to-left square-and-multiply on plain integers
  function automatic longint ref_pow(longint b, longint e, longint esz, longint m);
    longint r  = 1 % m;
    longint bb = b % m;
    for (int i = 0; i < esz; i++) begin
      if (((e >> i) & 1) != 0) r = (r * bb) % m;
      bb = (bb * bb) % m;
    end
    return r;
  endfunction

  function automatic longint ref_lat(longint e, longint esz, longint msz, bit ct);
    longint em = e & ((64'd1 << esz) - 1);
    longint nm = ct ? 3 + 2 * esz : 3 + esz + $countones(em);
    return nm * (msz + 2) + 1;
  endfunction

  function automatic vec8_t rand_vec8();
    vec8_t  v;
    longint lo;
    v.msz = $urandom_range(1, 8);
    lo    = 64'd1 << (v.msz - 1);
    v.m   = (lo + ($urandom % lo)) | 1;
    v.a   = $urandom % v.m;
    v.e   = $urandom & 255;
    v.esz = $urandom_range(0, 8);
    v.rr  = (64'd1 << (2 * v.msz)) % v.m;
    v.y   = ref_pow(v.a, v.e, v.esz, v.m);
    v.err = 0;
    v.cyc    = ref_lat(v.e, v.esz, v.msz, 1'b0);
    v.cyc_ct = ref_lat(v.e, v.esz, v.msz, 1'b1);
    return v;
  endfunction

  // start in cycle 0; at cycle act_cyc pulse abort (or a competing valid start)
  task automatic run8(input vec8_t v, input int act_cyc, input bit act_abort, input int limit);
    @(negedge clk);
    a8 = v.a[7:0]; exp8 = v.e[7:0]; esz8 = v.esz[11:0];
    m8 = v.m[7:0]; msz8 = v.msz[11:0]; rr8 = v.rr[7:0];
    start8 = 1'b1;
    dc0 = -1; dc1 = -1; nd0 = 0; nd1 = 0;
    ys0 = -1; ys1 = -1; es0 = -1; es1 = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      abort8 = 1'b0;
      if (k == 1) begin
        a8 = ~a8; exp8 = ~exp8; m8 = ~m8; rr8 = ~rr8;
      end
      blog0[k] = busy0;
      blog1[k] = busy1;
      if (done0) begin
        nd0++;
        if (dc0 < 0) begin dc0 = k; ys0 = y0; es0 = err0; end
      end
      if (done1) begin
        nd1++;
        if (dc1 < 0) begin dc1 = k; ys1 = y1; es1 = err1; end
      end
      if (k == act_cyc) begin
        if (act_abort) abort8 = 1'b1;
        else begin
          start8 = 1'b1;
          a8 = 8'd2; exp8 = 8'd5; esz8 = 12'd3; m8 = 8'd13; msz8 = 12'd4; rr8 = 8'd9;
        end
      end
    end
  endtask

  task automatic check8(input string tag, input vec8_t v, input int limit);
    bit any0 = 1'b0;
    bit any1 = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      any0 |= blog0[k];
      any1 |= blog1[k];
    end
    check({tag, " y"}, ys0, v.y);
    check({tag, " err"}, es0, v.err);
    check({tag, " done cycle"}, dc0, v.cyc);
    check({tag, " done count"}, nd0, 1);
    check({tag, " ct y"}, ys1, v.y);
    check({tag, " ct done cycle"}, dc1, v.cyc_ct);
    check({tag, " ct done count"}, nd1, 1);
    if (v.err != 0) begin
      check({tag, " busy never"}, any0 | any1, 0);
    end else begin
      check({tag, " busy cycle1"}, blog0[1], 1);
      check({tag, " busy at done"}, blog0[v.cyc], 0);
    end
  endtask

  task automatic run16(input int idx);
    longint lo, msz, m, a, e, esz, rr, ey, ec;
    int     dc, nd;
    longint ys, es;
    msz = (idx % 2 == 0) ? 16 : $urandom_range(1, 16);
    lo  = 64'd1 << (msz - 1);
    m   = (lo + ($urandom % lo)) | 1;
    a   = $urandom % m;
    e   = $urandom & 16'hFFFF;
    esz = (idx % 3 == 0) ? 16 : $urandom_range(0, 16);
    rr  = (64'd1 << (2 * msz)) % m;
    ey  = ref_pow(a, e, esz, m);
    ec  = ref_lat(e, esz, msz, 1'b0);
    @(negedge clk);
    a16 = a[15:0]; exp16 = e[15:0]; esz16 = esz[11:0];
    m16 = m[15:0]; msz16 = msz[11:0]; rr16 = rr[15:0];
    start16 = 1'b1;
    dc = -1; nd = 0; ys = -1; es = -1;
    for (int k = 1; k <= ec + 5; k++) begin
      @(negedge clk);
      start16 = 1'b0;
      if (done16) begin
        nd++;
        if (dc < 0) begin dc = k; ys = y16; es = err16; end
      end
    end
    check($sformatf("rnd16 %0d y", idx), ys, ey);
    check($sformatf("rnd16 %0d err", idx), es, 0);
    check($sformatf("rnd16 %0d done cycle", idx), dc, ec);
    check($sformatf("rnd16 %0d done count", idx), nd, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0;
    start8 = 1'b0; abort8 = 1'b0;
    a8 = '0; exp8 = '0; esz8 = '0; m8 = '0; msz8 = '0; rr8 = '0;
    start16 = 1'b0; abort16 = 1'b0;
    a16 = '0; exp16 = '0; esz16 = '0; m16 = '0; msz16 = '0; rr16 = '0;

    tbl[0] = '{7, 5, 3, 13, 4, 9, 11, 0, 49, 55};
    tbl[1] = '{7, 5, 3, 12, 4, 9, 0, 1, 1, 1};
    tbl[2] = '{7, 7, 3, 13, 4, 9, 6, 0, 55, 55};
    tbl[3] = '{7, 5, 0, 13, 4, 9, 1, 0, 19, 19};
    tbl[4] = '{7, 5, 3, 13, 9, 9, 0, 1, 1, 1};
    tbl[5] = '{7, 8'hF5, 3, 13, 4, 9, 11, 0, 49, 55};
    tbl[6] = '{7, 5, 9, 13, 4, 9, 0, 1, 1, 1};
    tbl[7] = '{2, 8'hFF, 8, 251, 8, 25, 0, 0, 191, 191};
    tbl[7].y = ref_pow(2, 255, 8, 251);
    tbl[8] = '{0, 3, 2, 1, 1, 0, 0, 0, 22, 22};
    tbl[9] = '{7, 5, 3, 13, 0, 9, 0, 1, 1, 1};

    repeat (3) @(negedge clk);
    check("reset y", y0, 0);
    check("reset busy", busy0, 0);
    check("reset done", done0, 0);
    check("reset err", err0, 0);
    check("reset ct busy", busy1, 0);
    check("reset wide y", y16, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run8(tbl[i], 0, 1'b0, 200);
      check8($sformatf("vec%0d", i), tbl[i], 200);
    end

    for (int i = 0; i < 20; i++) begin
      vec8_t v = rand_vec8();
      run8(v, 0, 1'b0, 200);
      check8($sformatf("rnd8 %0d", i), v, 200);
    end

    // abort in cycle 10 of the basic run; previous result must survive
    run8(tbl[0], 0, 1'b0, 60);
    run8(tbl[0], 10, 1'b1, 120);
    check("abort busy c10", blog0[10], 1);
    check("abort busy c11", blog0[11], 0);
    check("abort ct busy c11", blog1[11], 0);
    check("abort done count", nd0, 0);
    check("abort ct done count", nd1, 0);
    check("abort y kept", y0, 11);
    check("abort ct y kept", y1, 11);
    check("abort err kept", err0, 0);

    run8(tbl[0], 0, 1'b0, 200);
    check8("restart", tbl[0], 200);

    // competing start while busy must be ignored
    run8(tbl[7], 5, 1'b0, 200);
    check8("start while busy", tbl[7], 200);

    for (int i = 0; i < 40; i++) run16(i);

    // reset in the middle of an operation
    @(negedge clk);
    a8 = 8'd7; exp8 = 8'd5; esz8 = 12'd3; m8 = 8'd13; msz8 = 12'd4; rr8 = 8'd9;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset y", y0, 0);
    check("midreset busy", busy0, 0);
    check("midreset done", done0, 0);
    check("midreset ct busy", busy1, 0);
    check("midreset ct y", y1, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done0 || done1) cnt++;
    end
    check("midreset no done", cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
